// File: rtl/window_mac_acc_if.sv
// Window-in / pixel-out bus of the 3x3 MAC accumulator.
// master: loader plus output writer side; slave: window_mac_acc.
interface window_mac_acc_if #(
    parameter int unsigned WEIGHT_WIDTH = 8
);
    logic                      act_valid;
    logic [3*WEIGHT_WIDTH-1:0] activate0;
    logic [3*WEIGHT_WIDTH-1:0] activate1;
    logic [3*WEIGHT_WIDTH-1:0] activate2;
    logic [3*WEIGHT_WIDTH-1:0] weight0;
    logic [3*WEIGHT_WIDTH-1:0] weight1;
    logic [3*WEIGHT_WIDTH-1:0] weight2;
    logic                      channel_end;
    logic                      img_end;
    logic [WEIGHT_WIDTH-1:0]   out_data;
    logic                      out_valid;
    logic                      out_last;
    logic                      out_ready;

    modport master (
        output act_valid, activate0, activate1, activate2,
        output weight0, weight1, weight2, channel_end, img_end,
        output out_ready,
        input  out_data, out_valid, out_last
    );

    modport slave (
        input  act_valid, activate0, activate1, activate2,
        input  weight0, weight1, weight2, channel_end, img_end,
        input  out_ready,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/window_mac_acc.sv
// 3x3 window multiply-accumulate across input channels with requantization.
// Pipeline: M (products, only when PIPE_MAC=1) -> S (adder tree) -> A (channel
// accumulator) -> Q (shift, saturate, valid/ready output register).
// Build option: define WINDOW_MAC_RELU_EN to saturate to unsigned 0..2^W-1
// with negatives forced to 0; otherwise saturate to the signed W-bit range.
module window_mac_acc #(
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned ACC_WIDTH    = 32,
    parameter int unsigned PIPE_MAC     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    window_mac_acc_if.slave        bus,
    input  logic [4:0]             shift,
    output logic                   busy,
    output logic                   overflow_err
);
    localparam int unsigned WW     = WEIGHT_WIDTH;
    localparam int unsigned NTAP   = 9;
    localparam int unsigned PROD_W = 2 * WW + 1;
    localparam int unsigned SUM_W  = PROD_W + 4;

`ifdef WINDOW_MAC_RELU_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(int'((2 ** WW) - 1));
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = '0;
`else
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(int'((2 ** (WW - 1)) - 1));
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(-int'(2 ** (WW - 1)));
`endif

    logic        [WW-1:0]        act_c  [NTAP];
    logic        [WW-1:0]        wgt_c  [NTAP];
    logic signed [PROD_W-1:0]    prod_c [NTAP];

    logic signed [PROD_W-1:0]    tree_p [NTAP];
    logic                        tree_valid;
    logic                        tree_chend;
    logic                        tree_last;
    logic                        m_valid_nxt_c;

    logic                        s_valid, s_valid_n;
    logic signed [SUM_W-1:0]     s_sum,   s_sum_n;
    logic                        s_chend, s_chend_n;
    logic                        s_last,  s_last_n;

    logic                        a_valid, a_valid_n;
    logic                        a_chend, a_chend_n;
    logic                        a_last,  a_last_n;
    logic signed [ACC_WIDTH-1:0] acc,     acc_n;
    logic                        first,   first_n;

    logic signed [ACC_WIDTH-1:0] shifted_c;
    logic signed [ACC_WIDTH-1:0] sat_c;
    logic                        load_c;

    logic [WW-1:0]               out_data_q,  out_data_n;
    logic                        out_valid_q, out_valid_n;
    logic                        out_last_q,  out_last_n;
    logic                        ovf_n;
    logic                        busy_n;

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

    // Unpack the window rows and kernel rows into tap order 0..8.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            act_c[k]     = bus.activate0[WW*k +: WW];
            act_c[3 + k] = bus.activate1[WW*k +: WW];
            act_c[6 + k] = bus.activate2[WW*k +: WW];
            wgt_c[k]     = bus.weight0[WW*k +: WW];
            wgt_c[3 + k] = bus.weight1[WW*k +: WW];
            wgt_c[6 + k] = bus.weight2[WW*k +: WW];
        end
    end

    // Unsigned activation times signed weight; the product always fits PROD_W.
    always_comb begin
        for (int i = 0; i < NTAP; i++) begin
            prod_c[i] = $signed({{(PROD_W - WW){1'b0}}, act_c[i]})
                      * $signed({{(PROD_W - WW){wgt_c[i][WW-1]}}, wgt_c[i]});
        end
    end

    generate
        if (PIPE_MAC != 0) begin : g_mac_pipe
            logic signed [PROD_W-1:0] m_prod [NTAP];
            logic                     m_valid;
            logic                     m_chend;
            logic                     m_last;

            // Stage M: register products and window flags.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < NTAP; i++) m_prod[i] <= '0;
                    m_valid <= 1'b0;
                    m_chend <= 1'b0;
                    m_last  <= 1'b0;
                end else begin
                    m_valid <= bus.act_valid;
                    if (bus.act_valid) begin
                        for (int i = 0; i < NTAP; i++) m_prod[i] <= prod_c[i];
                        m_chend <= bus.channel_end;
                        m_last  <= bus.img_end;
                    end
                end
            end

            // Adder tree is fed from the product registers.
            always_comb begin
                for (int i = 0; i < NTAP; i++) tree_p[i] = m_prod[i];
                tree_valid    = m_valid;
                tree_chend    = m_chend;
                tree_last     = m_last;
                m_valid_nxt_c = bus.act_valid;
            end
        end else begin : g_mac_comb
            // Adder tree is fed straight from the multipliers.
            always_comb begin
                for (int i = 0; i < NTAP; i++) tree_p[i] = prod_c[i];
                tree_valid    = bus.act_valid;
                tree_chend    = bus.channel_end;
                tree_last     = bus.img_end;
                m_valid_nxt_c = 1'b0;
            end
        end
    endgenerate

    // Next-state for stages S, A, Q and the status outputs.
    always_comb begin
        s_valid_n   = tree_valid;
        s_sum_n     = s_sum;
        s_chend_n   = s_chend;
        s_last_n    = s_last;
        a_valid_n   = s_valid;
        a_chend_n   = a_chend;
        a_last_n    = a_last;
        acc_n       = acc;
        first_n     = first;
        out_data_n  = out_data_q;
        out_valid_n = out_valid_q;
        out_last_n  = out_last_q;
        ovf_n       = overflow_err;
        shifted_c   = '0;
        sat_c       = '0;
        load_c      = 1'b0;
        busy_n      = 1'b0;

        // Stage S: sign-extended 9-input sum.
        if (tree_valid) begin
            s_sum_n = '0;
            for (int i = 0; i < NTAP; i++) begin
                s_sum_n = s_sum_n + SUM_W'(tree_p[i]);
            end
            s_chend_n = tree_chend;
            s_last_n  = tree_last;
        end

        // Stage A: first window of a pixel replaces the sum, others add (wraps).
        if (s_valid) begin
            acc_n     = (first ? '0 : acc) + ACC_WIDTH'(s_sum);
            first_n   = s_chend;
            a_chend_n = s_chend;
            a_last_n  = s_last;
        end

        // Stage Q: arithmetic shift sign-fills for any shift amount, then clamp.
        shifted_c = acc >>> shift;
        if (shifted_c > SAT_HI) begin
            sat_c = SAT_HI;
        end else if (shifted_c < SAT_LO) begin
            sat_c = SAT_LO;
        end else begin
            sat_c = shifted_c;
        end

        load_c = a_valid && a_chend;
        if (out_valid_q && bus.out_ready) begin
            out_valid_n = 1'b0;
        end
        if (load_c) begin
            out_data_n  = WW'(sat_c);
            out_valid_n = 1'b1;
            out_last_n  = a_last;
            if (out_valid_q && !bus.out_ready) begin
                ovf_n = 1'b1;
            end
        end

        busy_n = m_valid_nxt_c || s_valid_n || a_valid_n || !first_n || out_valid_n;
    end

    // State registers for stages S, A, Q and the status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_valid      <= 1'b0;
            s_sum        <= '0;
            s_chend      <= 1'b0;
            s_last       <= 1'b0;
            a_valid      <= 1'b0;
            a_chend      <= 1'b0;
            a_last       <= 1'b0;
            acc          <= '0;
            first        <= 1'b1;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            overflow_err <= 1'b0;
            busy         <= 1'b0;
        end else begin
            s_valid      <= s_valid_n;
            s_sum        <= s_sum_n;
            s_chend      <= s_chend_n;
            s_last       <= s_last_n;
            a_valid      <= a_valid_n;
            a_chend      <= a_chend_n;
            a_last       <= a_last_n;
            acc          <= acc_n;
            first        <= first_n;
            out_data_q   <= out_data_n;
            out_valid_q  <= out_valid_n;
            out_last_q   <= out_last_n;
            overflow_err <= ovf_n;
            busy         <= busy_n;
        end
    end
endmodule

// File: tb/tb_window_mac_acc.sv
// Directed bench for window_mac_acc (default PIPE_MAC=1, 4-cycle latency).
module tb_window_mac_acc;
    localparam int unsigned WW   = 8;
    localparam int unsigned NVEC = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] shift;
    logic       busy;
    logic       overflow_err;

    int n_vec = 0;
    int n_err = 0;

    window_mac_acc_if #(.WEIGHT_WIDTH(WW)) bus ();

    window_mac_acc #(
        .WEIGHT_WIDTH (WW),
        .ACC_WIDTH    (32),
        .PIPE_MAC     (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .shift        (shift),
        .busy         (busy),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

`ifdef WINDOW_MAC_RELU_EN
    localparam logic [7:0] E_POS_SAT = 8'd255;
    localparam logic [7:0] E_NEG_SAT = 8'd0;
    localparam logic [7:0] E_NEG14   = 8'd0;
    localparam logic [7:0] E_NEG1    = 8'd0;
    localparam logic [7:0] E_175     = 8'd175;
    localparam logic [7:0] E_143     = 8'd143;
    localparam logic [7:0] E_NEG27   = 8'd0;
`else
    localparam logic [7:0] E_POS_SAT = 8'd127;
    localparam logic [7:0] E_NEG_SAT = 8'h80;
    localparam logic [7:0] E_NEG14   = 8'hF2;
    localparam logic [7:0] E_NEG1    = 8'hFF;
    localparam logic [7:0] E_175     = 8'd127;
    localparam logic [7:0] E_143     = 8'd127;
    localparam logic [7:0] E_NEG27   = 8'hE5;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] w;
        logic       ce;
        logic       ie;
        logic [4:0] sh;
        logic       exp_v;
        logic [7:0] exp_d;
        logic       exp_l;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic set_window(input logic [7:0] a, input logic [7:0] w,
                              input logic ce, input logic ie);
        bus.act_valid   = 1'b1;
        bus.activate0   = {3{a}};
        bus.activate1   = {3{a}};
        bus.activate2   = {3{a}};
        bus.weight0     = {3{w}};
        bus.weight1     = {3{w}};
        bus.weight2     = {3{w}};
        bus.channel_end = ce;
        bus.img_end     = ie;
    endtask

    task automatic clear_window();
        bus.act_valid   = 1'b0;
        bus.channel_end = 1'b0;
        bus.img_end     = 1'b0;
    endtask

    // One-cycle window pulse; returns 1 ns after the edge that samples it.
    task automatic drive_window(input logic [7:0] a, input logic [7:0] w,
                                input logic ce, input logic ie);
        @(posedge clk); #1;
        set_window(a, w, ce, ie);
        @(posedge clk); #1;
        clear_window();
    endtask

    // Window, then expect out_valid exactly 4 cycles after the pulse cycle.
    task automatic run_expect(input string name, input logic [7:0] a, input logic [7:0] w,
                              input logic ce, input logic ie, input logic [4:0] sh,
                              input logic exp_v, input logic [7:0] exp_d, input logic exp_l);
        logic early;
        shift = sh;
        drive_window(a, w, ce, ie);
        early = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            early = early | bus.out_valid;
        end
        @(negedge clk);
        check({name, " early_valid"}, 32'(early), 32'd0);
        check({name, " out_valid"}, 32'(bus.out_valid), 32'(exp_v));
        if (exp_v) begin
            check({name, " out_data"}, 32'(bus.out_data), 32'(exp_d));
            check({name, " out_last"}, 32'(bus.out_last), 32'(exp_l));
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b_exp [4];

        vecs[0]  = '{8'd1,   8'd1,   1'b1, 1'b1, 5'd0,  1'b1, 8'd9,      1'b1};
        vecs[1]  = '{8'd10,  8'd2,   1'b0, 1'b0, 5'd1,  1'b0, 8'd0,      1'b0};
        vecs[2]  = '{8'd10,  8'hFF,  1'b0, 1'b0, 5'd1,  1'b0, 8'd0,      1'b0};
        vecs[3]  = '{8'd0,   8'd5,   1'b1, 1'b0, 5'd1,  1'b1, 8'd45,     1'b0};
        vecs[4]  = '{8'd1,   8'd1,   1'b1, 1'b0, 5'd0,  1'b1, 8'd9,      1'b0};
        vecs[5]  = '{8'd255, 8'd127, 1'b1, 1'b0, 5'd0,  1'b1, E_POS_SAT, 1'b0};
        vecs[6]  = '{8'd255, 8'h80,  1'b1, 1'b0, 5'd0,  1'b1, E_NEG_SAT, 1'b0};
        vecs[7]  = '{8'd3,   8'hFE,  1'b1, 1'b0, 5'd2,  1'b1, E_NEG14,   1'b0};
        vecs[8]  = '{8'd1,   8'd1,   1'b1, 1'b0, 5'd31, 1'b1, 8'd0,      1'b0};
        vecs[9]  = '{8'd1,   8'hFF,  1'b1, 1'b0, 5'd31, 1'b1, E_NEG1,    1'b0};
        vecs[10] = '{8'd2,   8'd1,   1'b0, 1'b1, 5'd0,  1'b0, 8'd0,      1'b0};
        vecs[11] = '{8'd1,   8'd1,   1'b1, 1'b0, 5'd0,  1'b1, 8'd27,     1'b0};
        vecs[12] = '{8'd100, 8'd50,  1'b1, 1'b0, 5'd8,  1'b1, E_175,     1'b0};
        vecs[13] = '{8'd255, 8'd1,   1'b1, 1'b0, 5'd4,  1'b1, E_143,     1'b0};
        vecs[14] = '{8'd14,  8'd1,   1'b1, 1'b1, 5'd0,  1'b1, 8'd126,    1'b1};

        b2b_exp[0] = 8'd9;
        b2b_exp[1] = 8'd18;
        b2b_exp[2] = E_NEG27;
        b2b_exp[3] = 8'd108;

        rst           = 1'b0;
        shift         = 5'd0;
        bus.out_ready = 1'b1;
        bus.activate0 = '0; bus.activate1 = '0; bus.activate2 = '0;
        bus.weight0   = '0; bus.weight1   = '0; bus.weight2   = '0;
        clear_window();
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data", 32'(bus.out_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset overflow_err", 32'(overflow_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table: single channel, multi-channel, saturation, shift corners.
        for (int v = 0; v < NVEC; v++) begin
            run_expect($sformatf("vec%0d", v), vecs[v].a, vecs[v].w, vecs[v].ce, vecs[v].ie,
                       vecs[v].sh, vecs[v].exp_v, vecs[v].exp_d, vecs[v].exp_l);
        end
        check("idle busy", 32'(busy), 32'd0);

        // Back-to-back windows, each closing a pixel: four outputs, no bubbles.
        shift = 5'd0;
        @(posedge clk); #1; set_window(8'd1, 8'd1,  1'b1, 1'b0);
        @(posedge clk); #1; set_window(8'd2, 8'd1,  1'b1, 1'b0);
        @(posedge clk); #1; set_window(8'd3, 8'hFF, 1'b1, 1'b0);
        @(posedge clk); #1; set_window(8'd4, 8'd3,  1'b1, 1'b1);
        @(posedge clk); #1; clear_window();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("b2b%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("b2b%0d out_data", i), 32'(bus.out_data), 32'(b2b_exp[i]));
            check($sformatf("b2b%0d out_last", i), 32'(bus.out_last), (i == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("b2b drain out_valid", 32'(bus.out_valid), 32'd0);
        check("b2b overflow_err", 32'(overflow_err), 32'd0);
        repeat (2) @(negedge clk);

        // Backpressure: second result overwrites the unaccepted first.
        bus.out_ready = 1'b0;
        drive_window(8'd1, 8'd1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("bp first out_valid", 32'(bus.out_valid), 32'd1);
        check("bp first out_data", 32'(bus.out_data), 32'd9);
        repeat (2) @(negedge clk);
        drive_window(8'd2, 8'd1, 1'b1, 1'b1);
        @(negedge clk);
        check("bp hold out_valid", 32'(bus.out_valid), 32'd1);
        check("bp hold out_data", 32'(bus.out_data), 32'd9);
        check("bp hold overflow_err", 32'(overflow_err), 32'd0);
        repeat (3) @(negedge clk);
        check("bp second out_data", 32'(bus.out_data), 32'd18);
        check("bp second out_last", 32'(bus.out_last), 32'd1);
        check("bp overflow_err set", 32'(overflow_err), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp accept out_valid", 32'(bus.out_valid), 32'd0);
        check("bp sticky overflow_err", 32'(overflow_err), 32'd1);
        check("bp drained busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);

        // Reset mid-run: pending output, partial sum and a window in flight.
        bus.out_ready = 1'b0;
        shift = 5'd0;
        drive_window(8'd1, 8'd1, 1'b1, 1'b0);
        drive_window(8'd5, 8'd5, 1'b0, 1'b0);
        drive_window(8'd3, 8'd3, 1'b0, 1'b0);
        @(negedge clk);
        check("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
        check("pre-reset busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async reset out_valid", 32'(bus.out_valid), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset overflow_err", 32'(overflow_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        run_expect("post-reset", 8'd1, 8'd1, 1'b1, 1'b1, 5'd0, 1'b1, 8'd9, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/window_mac_acc.md
Name: window_mac_acc

Overview:
- Downstream consumer of the 3x3 activation window loader.
- On each loader `done` pulse it multiplies the 9 activations by 9 signed weights and sums them.
- It accumulates across input channels until the channel-end flag, then requantizes the channel sum to 8 bits.
- The 8-bit result is presented on a valid/ready output toward the output writer.

Parameters:
WEIGHT_WIDTH, 8, width of one activation / weight element
ACC_WIDTH, 32, signed accumulator width (must be >= 2*WEIGHT_WIDTH+5)
PIPE_MAC, 1, 1 = register the products before the adder tree; 0 = products feed the tree combinationally (latency drops by 1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
act_valid  in  1  one-cycle pulse; window and flags valid this cycle (driven by loader `done`)
activate0  in  3*WEIGHT_WIDTH  window row 0, unsigned, element k at bits [8k+:8]
activate1  in  3*WEIGHT_WIDTH  window row 1, unsigned
activate2  in  3*WEIGHT_WIDTH  window row 2, unsigned
weight0  in  3*WEIGHT_WIDTH  kernel row 0, signed two's complement, same packing as activate0
weight1  in  3*WEIGHT_WIDTH  kernel row 1, signed
weight2  in  3*WEIGHT_WIDTH  kernel row 2, signed
channel_end  in  1  sampled with act_valid; this window is the last channel of the output pixel
img_end  in  1  sampled with act_valid; this window is the last of the image
shift  in  5  static right-shift amount for requantization
out_data  out  WEIGHT_WIDTH  requantized output pixel
out_valid  out  1  out_data valid; held until accepted
out_last  out  1  qualifies out_data as the last pixel of the image
out_ready  in  1  consumer accepts when out_valid && out_ready
busy  out  1  any window in flight or accumulator nonzero-pending
overflow_err  out  1  sticky; a result was overwritten before acceptance

Behaviour:
- Reset (rst=0, async): all pipeline valids, accumulator, out_data, out_valid, out_last, busy and overflow_err go to 0 immediately. Any in-flight window is discarded. A partial channel sum is lost.
- Stage M (PIPE_MAC=1): 9 products p = $unsigned(a) * $signed(w), each 17-bit signed. The products are registered together with the valid, channel_end and img_end flags.
- Stage S: 9-input adder tree, sign-extended to 21 bits, registered.
- Stage A:
  - acc <= (first ? 0 : acc) + sext(sum).
  - `first` is set at reset and after every channel_end, which gives an implicit clear.
  - Accumulator wrap is two's complement modulo 2^ACC_WIDTH; there is no saturation inside the accumulator.
- Stage Q, on an accumulation with channel_end=1:
  - r = acc_new >>> shift (arithmetic).
  - Saturate r per the Optional Feature.
  - Load out_data, set out_valid=1, set out_last=img_end.
- Latency: act_valid at cycle T with channel_end → out_valid high at T+4 (PIPE_MAC=1) or T+3 (PIPE_MAC=0).
- Throughput: one window per cycle is accepted. Back-to-back act_valid pulses are legal; the loader never issues faster than one per 7 cycles.
- Output handshake:
  - out_valid stays high and out_data/out_last stay stable until the cycle where out_ready=1.
  - out_valid clears the following edge unless a new result loads in the same cycle, in which case the new result is presented with no bubble.
- Overrun: a new result arriving while out_valid=1 && out_ready=0 overwrites out_data/out_last and sets overflow_err. overflow_err is cleared only by reset.
- img_end without channel_end is a protocol error. It is ignored, and out_last is only taken with channel_end.
- busy = any stage valid || !first || out_valid.
- shift >= ACC_WIDTH yields r = 0 or -1 (sign fill).

Optional Feature:
- Macro WINDOW_MAC_RELU_EN.
- Defined:
  - r < 0 → 0, else min(r, 255).
  - out_data is unsigned 0..255.
- Undefined:
  - r is clamped to [-128, 127].
  - out_data is two's complement.
- All other timing is identical in both builds.

Test Plan:
1. Reset mid-run: windows in flight, then rst low for one cycle → out_valid=0, busy=0, overflow_err=0 asynchronously, before the next clk edge. Next window starts a fresh sum.
2. Single channel: all activations 1, all weights 1, shift=0, channel_end=1, img_end=1 → out_data=9, out_valid at T+4, out_last=1.
3. Three channels: channel 0 with activations all 10 and weights all 2 (180), channel 1 with weights all -1 (-90), channel 2 with activations 0, channel_end on the third window, shift=1 → out_data=45. Then a following single-channel window with activations 1 and weights 1 → out_data=9, proving the accumulator cleared.
4. Saturation: activations 255, weights 127, shift=0 → 255 with WINDOW_MAC_RELU_EN, 127 without. Weights -128 → 0 with the macro, -128 (0x80) without.
5. Backpressure: out_ready=0, two channel_end results 7 cycles apart → second value presented, overflow_err=1. Then out_ready=1 → out_valid drops the next cycle.
6. Back-to-back act_valid every cycle for 4 windows with channel_end on each → four consecutive out_valid cycles with out_ready=1 and no bubbles, values matching a model.
